// File: rtl/or1k_startup_rom_wb.sv
// Wishbone B3 read-only slave front-end for the OR1K startup ROM.
// Turns classic and incrementing-burst reads into ROM word addresses and errors every write.
module or1k_startup_rom_wb #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned ROM_WORDS  = 32
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_dout
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam logic [2:0] CtiIncr = 3'b010;

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  oor_q, oor_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req, wreq, incr;
  logic                  unused_inputs;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [1:0]            bte);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    unique case (bte)
      2'b00: r      = a + ADDR_WIDTH'(1);
      2'b01: r[1:0] = a[1:0] + 2'd1;
      2'b10: r[2:0] = a[2:0] + 3'd1;
      2'b11: r[3:0] = a[3:0] + 4'd1;
    endcase
    return r;
  endfunction

  assign req      = wb_cyc_i & wb_stb_i & ~wb_we_i;
  assign wreq     = wb_cyc_i & wb_stb_i & wb_we_i;
  assign incr     = (wb_cti_i == CtiIncr);
  assign word_idx = wb_adr_i[ADDR_WIDTH+1:2];
  assign rom_addr = (state_q == StBurst) ? burst_addr_q : word_idx;

  // Latched on the same edge as the ROM address so it lines up with rom_dout.
  assign oor_d = (32'(rom_addr) >= ROM_WORDS);

  assign unused_inputs = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    burst_addr_d = burst_addr_q;
    case (state_q)
      StIdle: begin
        if (req && !ack_q) begin
          ack_d = 1'b1;
          if (incr) begin
            state_d      = StBurst;
            burst_addr_d = wrap_inc(word_idx, wb_bte_i);
          end
        end
        err_d = wreq & ~err_q;
      end
      StBurst: begin
        // Dropped strobe or a non-incrementing beat ends the burst; the last beat is already acked.
        if (!req || (ack_q && !incr)) begin
          state_d = StIdle;
        end else begin
          ack_d = 1'b1;
          if (ack_q) burst_addr_d = wrap_inc(burst_addr_q, wb_bte_i);
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= StIdle;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      oor_q        <= 1'b0;
      burst_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      oor_q        <= oor_d;
      burst_addr_q <= burst_addr_d;
    end
  end

  // Qualify with the live strobe so an abandoned burst never sees a stale ack.
  assign wb_ack_o = ack_q & req;
  assign wb_err_o = err_q & wreq;
  assign wb_dat_o = (wb_ack_o && !oor_q) ? rom_dout : 32'd0;

endmodule

// File: tb/tb_or1k_startup_rom_wb.sv
// Scoreboard bench for or1k_startup_rom_wb with a registered-address ROM model.
module tb_or1k_startup_rom_wb;

  logic        clk, rst_n;
  logic [31:0] adr, dat_i, dat_o, rom_dout;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [6:0]  rom_addr;

  logic [31:0] rom_mem [0:127];

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } resp_t;

  resp_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  or1k_startup_rom_wb #(.ADDR_WIDTH(7), .ROM_WORDS(32)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_dout <= rom_mem[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int idx);
    return (idx < 32) ? rom_mem[idx] : 32'd0;
  endfunction

  function automatic int next_idx(input int a, input logic [1:0] b);
    int m;
    case (b)
      2'b00:   return (a + 1) % 128;
      2'b01:   m = 4;
      2'b10:   m = 8;
      default: m = 16;
    endcase
    return (a / m) * m + ((a % m) + 1) % m;
  endfunction

  always @(negedge clk) begin
    resp_t e;
    if (rst_n && (ack || err)) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_resp", {30'd0, ack, err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("resp_kind", {30'd0, ack, err}, e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) check_eq("rd_data", dat_o, e.data);
      end
    end
  end

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  task automatic classic_read(input logic [31:0] a, input string tag);
    int lat;
    bit got;
    sb_q.push_back('{is_err: 1'b0, data: exp_word(int'(a[8:2]))});
    @(posedge clk); #1;
    adr = a; we = 1'b0; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    lat = 0; got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (i == 0) check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'(a[8:2]));
      if (ack) got = 1;
      else lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd1);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check_eq({tag, "_ack_pulse"}, 32'(ack), 32'd0);
  endtask

  // Runs n beats; with stop_at > 0 the master walks away after stop_at acks (stb dropped).
  task automatic burst_read(input logic [31:0] a, input logic [1:0] b, input int n,
                            input int stop_at, input string tag);
    int idx, beats, cnt, first, last, want;
    want = (stop_at > 0) ? stop_at : n;
    idx  = int'(a[8:2]);
    for (int i = 0; i < want; i++) begin
      sb_q.push_back('{is_err: 1'b0, data: exp_word(idx)});
      idx = next_idx(idx, b);
    end
    @(posedge clk); #1;
    adr = a; we = 1'b0; cti = 3'b010; bte = b; cyc = 1'b1; stb = 1'b1;
    beats = 0; cnt = 0; first = -1; last = -1;
    while (beats < want && cnt < 4 * n + 8) begin
      @(negedge clk);
      if (ack) begin
        beats++;
        if (first < 0) first = cnt;
        last = cnt;
      end
      cnt++;
      @(posedge clk); #1;
      if (stop_at > 0 && beats == stop_at) stb = 1'b0;
      else if (beats == n - 1) cti = 3'b111;
    end
    check_eq({tag, "_beats"}, 32'(beats), 32'(want));
    check_eq({tag, "_first"}, 32'(first), 32'd1);
    check_eq({tag, "_span"}, 32'(last - first), 32'(want - 1));
    @(negedge clk);
    check_eq({tag, "_ack_end"}, 32'(ack), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    adr = 32'h0000_0014;
    @(negedge clk);
    check_eq({tag, "_idle"}, 32'(rom_addr), 32'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = (i < 32) ? (32'h1000_0000 | i) : (32'hBAD0_0000 | i);
    rom_mem[0]  = 32'h1800_0000;
    rom_mem[1]  = 32'hA820_0000;
    rom_mem[2]  = 32'hA8A0_0520;
    rom_mem[3]  = 32'hA860_0001;
    rom_mem[4]  = 32'h0400_0014;
    rom_mem[5]  = 32'hD404_1818;
    rom_mem[12] = 32'hD404_0000;
    rom_mem[13] = 32'hE043_1804;
    rom_mem[14] = 32'hE408_0000;
    rom_mem[15] = 32'h0FFF_FFFB;

    rst_n = 1'b0; adr = '0; dat_i = '0; sel = 4'hF;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_dat", dat_o, 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;

    classic_read(32'h0000_0000, "classic0");
    burst_read(32'h0000_0008, 2'b00, 4, 0, "lin");
    burst_read(32'h0000_0038, 2'b01, 4, 0, "wrap4");
    burst_read(32'h0000_0018, 2'b10, 4, 0, "wrap8");
    burst_read(32'h0000_0078, 2'b11, 4, 0, "wrap16");
    burst_read(32'h0000_0078, 2'b00, 4, 0, "lin_oor");

    // Write is errored, never acked.
    sb_q.push_back('{is_err: 1'b1, data: 32'd0});
    @(posedge clk); #1;
    adr = 32'h4; we = 1'b1; cyc = 1'b1; stb = 1'b1; dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("wr_err_early", 32'(err), 32'd0);
    @(negedge clk);
    check_eq("wr_err", 32'(err), 32'd1);
    check_eq("wr_no_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check_eq("wr_err_pulse", 32'(err), 32'd0);
    classic_read(32'h0000_0004, "rd_after_wr");

    burst_read(32'h0000_0040, 2'b00, 4, 2, "abort");
    classic_read(32'h0000_0080, "oor");

    // Reset asserted mid-burst.
    sb_q.push_back('{is_err: 1'b0, data: exp_word(2)});
    sb_q.push_back('{is_err: 1'b0, data: exp_word(3)});
    @(posedge clk); #1;
    adr = 32'h8; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    begin
      int beats;
      beats = 0;
      for (int i = 0; i < 10 && beats < 2; i++) begin
        @(negedge clk);
        if (ack) beats++;
      end
      check_eq("rst_mid_beats", 32'(beats), 32'd2);
    end
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ack", 32'(ack), 32'd0);
    check_eq("rst_mid_err", 32'(err), 32'd0);
    idle_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_idle_ack", 32'(ack), 32'd0);
    check_eq("rst_mid_idle", 32'(rom_addr), 32'd2);

    classic_read(32'h0000_000C, "post_rst");
    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/or1k_startup_rom_wb.md
Name: or1k_startup_rom_wb

Overview:
- Wishbone B3 slave front-end for the OR1K startup ROM.
- Sits between the instruction/data bus arbiter and the ROM; the ROM registers its address, so read data appears one clock after the address.
- Converts single and incrementing-burst (linear or wrapping) read cycles into ROM word addresses and returns data with ack.
- Rejects writes with an error response.

Parameters:
- ADDR_WIDTH, 7: width of ROM word-address port rom_addr.
- ROM_WORDS, 32: number of populated ROM words; word indices >= ROM_WORDS read as zero.

Ports:
- wb_clk  in  1  bus clock; also clocks the ROM.
- wb_rst_n  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  byte address; word index = wb_adr_i[ADDR_WIDTH+1:2].
- wb_dat_i  in  32  write data (ignored).
- wb_sel_i  in  4  byte selects (ignored; reads always full word).
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 4-beat wrap, 10 8-beat wrap, 11 16-beat wrap.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  registered acknowledge.
- wb_err_o  out  1  registered error.
- rom_addr  out  ADDR_WIDTH  word address to ROM; the ROM latches it on wb_clk.
- rom_dout  in  32  ROM data for the address latched on the previous edge.

Behaviour:
- Reset (async assert, sync release): state=IDLE, wb_ack_o=0, wb_err_o=0, burst_addr=0, oor_r=0. wb_dat_o=0 while ack is low.
- req = wb_cyc_i & wb_stb_i & !wb_we_i.
- wreq = wb_cyc_i & wb_stb_i & wb_we_i.
- rom_addr (combinational):
  - IDLE: word index of wb_adr_i.
  - BURST: burst_addr.
- IDLE:
  - On req & !wb_ack_o, wb_ack_o goes high at the next edge. Latency is 1 cycle; data = rom_dout for that address.
  - The ack is a single-cycle pulse; ack is never asserted two consecutive cycles in IDLE.
  - If additionally wb_cti_i==010: next state is BURST, and burst_addr <= wrap_inc(word index).
- BURST:
  - wb_ack_o <= req every cycle, giving zero wait states after the first beat.
  - On each edge where wb_ack_o=1 and the master still presents wb_cti_i==010 with req: burst_addr <= wrap_inc(burst_addr).
  - Exit to IDLE at the edge where wb_ack_o=1 and (wb_cti_i!=010 or !req). The beat presented with cti=111 is still acked exactly once, at that same edge.
  - If stb or cyc drops mid-burst: ack is low next cycle and the state is IDLE (abort). No stale ack.
- wrap_inc(a):
  - bte 00: a+1 modulo 2^ADDR_WIDTH.
  - bte 01: a[1:0] increments with wrap; upper bits held.
  - bte 10: a[2:0] increments with wrap; upper bits held.
  - bte 11: a[3:0] increments with wrap; upper bits held.
  - bte is sampled each beat.
- Out of range: oor_r <= (rom_addr >= ROM_WORDS), registered alongside the ROM.
- wb_dat_o = (wb_ack_o & !oor_r) ? rom_dout : 0.
- Writes:
  - wreq & !wb_err_o: wb_err_o pulses high one cycle at the next edge. No ack; ROM contents unaffected.
  - A write in BURST (we rises mid-burst) ends the burst as an abort, then is errored as in IDLE.
- Ack and err are never high together.
- wb_cti_i=000 in IDLE is a classic cycle: single ack pulse. A back-to-back classic read needs stb held, so acks occur every other cycle.
- Reset asserted mid-burst: ack/err drop immediately, state=IDLE.

Test Plan:
- Classic read: adr=0x0, cyc=stb=1, cti=000 -> ack one cycle after request, dat_o=0x18000000; ack low the following cycle; rom_addr=0.
- Linear burst: adr=0x8, cti=010, bte=00 for 3 beats then cti=111 -> 4 consecutive ack cycles starting at request+1, data 0xA8A00520, 0xA8600001, 0x04000014, 0xD4041818; then IDLE, ack low.
- 4-beat wrap: adr=0x38 (word 14), bte=01, cti=010 for 3 beats then 111 -> words 14,15,12,13: 0xE4080000, 0x0FFFFFFB, 0xD4040000, 0xE0431804.
- Write: we=1, adr=0x4 -> wb_err_o one-cycle pulse one cycle later, ack never asserted; a subsequent read of 0x4 returns 0xA8200000.
- Abort and reset: drop stb after the 2nd beat of a linear burst -> ack low next cycle, state IDLE. Separately, assert wb_rst_n=0 mid-burst -> ack=0 immediately. Out of range: read adr=0x80 (word 32) -> ack with dat_o=0.
